// File: rtl/spram_arbiter.sv
// Round-robin two-port sequencer for the 128 KiB SPRAM bank.
// Also drives the bank's standby/sleep pins with idle timeout and wake sequencing.
module spram_arbiter #(
    parameter int IDLE_STANDBY = 64,
    parameter int WAKE_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [16:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic        a_rvalid,
    output logic [7:0]  a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [16:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic        b_rvalid,
    output logic [7:0]  b_rdata,
    input  logic        sleep_req,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_wren,
    output logic        mem_cs,
    output logic        mem_standby,
    output logic        mem_sleep,
    output logic        mem_poweroff_n,
    input  logic [7:0]  mem_dout
);

    localparam int IW = (IDLE_STANDBY > 0) ? $clog2(IDLE_STANDBY + 1) : 1;
    localparam int WW = $clog2(WAKE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_STANDBY);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);
    localparam bit WAKE_SKIP = (WAKE_CYCLES <= 1);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_STANDBY,
        ST_SLEEP,
        ST_WAKE
    } state_e;

    state_e        state_q, state_d, wake_tgt;
    logic          rr_q, rr_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [WW-1:0] wake_q, wake_d;

    logic [16:0] mem_addr_q;
    logic [7:0]  mem_din_q;
    logic        mem_wren_q, mem_cs_q;
    logic        mem_standby_q, mem_sleep_q;
    logic        rd1_q, tag1_q, rd2_q, tag2_q;

    logic grant_a, grant_b, any_req, empty, active;

    assign any_req  = a_req | b_req;
    assign empty    = ~mem_cs_q & ~rd2_q;
    // the trigger cycle counts as the first low-pin cycle
    assign wake_tgt = WAKE_SKIP ? ST_ACTIVE : ST_WAKE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACTIVE;
            rr_q    <= 1'b0;
            idle_q  <= '0;
            wake_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACTIVE: begin
                if (sleep_req) begin
                    if (empty) state_d = ST_SLEEP;
                end else if (IDLE_STANDBY != 0 && idle_q == IDLE_MAX
                             && !any_req && empty) begin
                    state_d = ST_STANDBY;
                end
            end
            ST_STANDBY: begin
                if (sleep_req)    state_d = ST_SLEEP;
                else if (any_req) state_d = wake_tgt;
            end
            ST_SLEEP: begin
                if (!sleep_req) state_d = wake_tgt;
            end
            ST_WAKE: begin
                if (sleep_req)                state_d = ST_SLEEP;
                else if (wake_q == WAKE_LAST) state_d = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_comb begin
        active  = (state_q == ST_ACTIVE) && !sleep_req && !rst;
        grant_a = active && a_req && (!b_req || !rr_q);
        grant_b = active && b_req && (!a_req || rr_q);
        rr_d = rr_q;
        if (grant_a)      rr_d = 1'b1;
        else if (grant_b) rr_d = 1'b0;
        idle_d = idle_q;
        if (state_q != ST_ACTIVE || any_req) idle_d = '0;
        else if (idle_q != IDLE_MAX)         idle_d = idle_q + IW'(1);
        wake_d = (state_q == ST_WAKE) ? wake_q + WW'(1) : WW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_wren_q    <= 1'b0;
            mem_cs_q      <= 1'b0;
            mem_standby_q <= 1'b0;
            mem_sleep_q   <= 1'b0;
            rd1_q         <= 1'b0;
            tag1_q        <= 1'b0;
            rd2_q         <= 1'b0;
            tag2_q        <= 1'b0;
        end else begin
            mem_cs_q   <= grant_a | grant_b;
            mem_wren_q <= grant_a ? a_we : (grant_b & b_we);
            if (grant_a) begin
                mem_addr_q <= a_addr;
                mem_din_q  <= a_wdata;
            end else if (grant_b) begin
                mem_addr_q <= b_addr;
                mem_din_q  <= b_wdata;
            end
            rd1_q         <= (grant_a & ~a_we) | (grant_b & ~b_we);
            tag1_q        <= grant_b;
            rd2_q         <= rd1_q;
            tag2_q        <= tag1_q;
            mem_standby_q <= (state_d == ST_STANDBY);
            mem_sleep_q   <= (state_d == ST_SLEEP);
        end
    end

    assign a_ack          = grant_a;
    assign b_ack          = grant_b;
    assign a_rvalid       = rd2_q & ~tag2_q;
    assign b_rvalid       = rd2_q & tag2_q;
    assign a_rdata        = mem_dout;
    assign b_rdata        = mem_dout;
    assign mem_addr       = mem_addr_q;
    assign mem_din        = mem_din_q;
    assign mem_wren       = mem_wren_q;
    assign mem_cs         = mem_cs_q;
    assign mem_standby    = mem_standby_q;
    assign mem_sleep      = mem_sleep_q;
    assign mem_poweroff_n = 1'b1;

endmodule
